// File: rtl/dual_buffer_pkg.sv
// Shared types and constants for the ping-pong packet buffer read side.
package dual_buffer_pkg;

  // Default half depth and the index/count widths that go with it.
  localparam int NUM_PACKETS_DEF = 8;
  localparam int PKT_IDX_W       = $clog2(NUM_PACKETS_DEF);
  localparam int PKT_CNT_W       = PKT_IDX_W + 1;

  // Read controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Half selector.
  typedef logic buf_sel_t;
  localparam buf_sel_t BUF_PING = 1'b0;
  localparam buf_sel_t BUF_PONG = 1'b1;

  // Flip to the other half.
  function automatic buf_sel_t other_buf(input buf_sel_t sel);
    return (sel == BUF_PING) ? BUF_PONG : BUF_PING;
  endfunction

endpackage

// File: rtl/dual_buffer_out_fifo.sv
// Two-entry valid/ready staging FIFO for captured packets.
// The producer side has no back-pressure: the caller only pushes when it
// has reserved a slot, and may push into a full FIFO in a cycle that pops.
module dual_buffer_out_fifo #(
  parameter int W = 16002
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  assign push      = in_valid;
  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];

  // Storage, pointers and occupancy; a full push+pop overwrites the
  // entry that is leaving on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/dual_buffer_reader.sv
// Read-side controller for the ping-pong packet buffer: serves committed
// halves in strict ping/pong alternation, streams the packets out through
// a two-entry FIFO and hands each half back once all of it is captured.
module dual_buffer_reader
  import dual_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH             = 16000,
  parameter  int NUM_PACKETS_PER_BUFFER = NUM_PACKETS_DEF,
  parameter  int RD_LATENCY             = 1,
  localparam int IDX_W                  = $clog2(NUM_PACKETS_PER_BUFFER),
  localparam int CNT_W                  = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid,
  input  logic                  commit_sel,
  input  logic [CNT_W-1:0]      commit_cnt,
  output logic                  release_valid,
  output logic                  release_sel,
  output logic                  rd_buf_sel,
  output logic [IDX_W-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_buf_sel,
  output logic                  err_commit
);

  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("dual_buffer_reader: only RD_LATENCY == 1 is supported");
  end
  if (NUM_PACKETS_PER_BUFFER < 2 ||
      (NUM_PACKETS_PER_BUFFER & (NUM_PACKETS_PER_BUFFER - 1)) != 0) begin : g_bad_depth
    $error("dual_buffer_reader: NUM_PACKETS_PER_BUFFER must be a power of two >= 2");
  end

  // Reset: asserted asynchronously, released on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_i;

  // Two-flop reset release synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  // Half bookkeeping.
  logic [1:0]            full;
  logic [1:0][CNT_W-1:0] cnt;
  buf_sel_t              cur_sel;
  logic [CNT_W-1:0]      cur_cnt;
  logic                  commit_ok;

  // Read sequencing.
  state_e                state, state_n;
  logic [IDX_W-1:0]      rd_idx, rd_idx_n;
  logic                  issue_slot;
  logic                  issue;
  logic                  issue_last;

  // Reads in flight, one stage per cycle of buffer latency.
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_last;
  logic [RD_LATENCY-1:0] pipe_sel;
  logic [2:0]            inflight;

  // Output staging.
  logic [1:0]            fifo_occ;
  logic                  pop;
  logic                  push;
  logic [2:0]            credit_use;
  logic                  credit_ok;
  logic                  release_now;
  logic [DATA_WIDTH+1:0] push_data;
  logic [DATA_WIDTH+1:0] head_data;

  assign cur_cnt    = cnt[cur_sel];
  assign commit_ok  = commit_valid && (commit_cnt != '0) &&
                      (commit_cnt <= CNT_W'(NUM_PACKETS_PER_BUFFER)) &&
                      !full[commit_sel];

  // A read may issue only if its data will find a FIFO slot. Occupancy is
  // taken net of this cycle's pop so a draining stream keeps 1 packet/cycle.
  assign inflight   = 3'($countones(pipe_vld));
  assign pop        = out_valid & out_ready;
  assign credit_use = 3'(fifo_occ) + inflight - 3'(pop);
  assign credit_ok  = (credit_use < 3'd2);

  // IDLE doubles as the slot for index 0, which keeps commit-to-first-read
  // and half-to-half gaps at a single cycle.
  assign issue_slot = (state == ISSUE) || ((state == IDLE) && full[cur_sel]);
  assign issue      = issue_slot && credit_ok;
  assign issue_last = (CNT_W'(rd_idx) == (cur_cnt - CNT_W'(1)));

  assign push        = pipe_vld[RD_LATENCY-1];
  assign release_now = (state == WAIT) && push && pipe_last[RD_LATENCY-1];

  assign rd_addr       = rd_idx;
  assign rd_buf_sel    = cur_sel;
  assign release_valid = release_now;
  assign release_sel   = cur_sel;

  // Next-state and read index for the issue sequencer.
  always_comb begin
    state_n  = state;
    rd_idx_n = rd_idx;
    unique case (state)
      IDLE: begin
        if (full[cur_sel]) begin
          state_n = ISSUE;
          if (issue) begin
            if (issue_last) state_n  = WAIT;
            else            rd_idx_n = rd_idx + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          if (issue_last) begin
            state_n  = WAIT;
            rd_idx_n = '0;
          end else begin
            rd_idx_n = rd_idx + 1'b1;
          end
        end
      end
      WAIT: begin
        if (release_now) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer state.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rd_idx <= '0;
    end else begin
      state  <= state_n;
      rd_idx <= rd_idx_n;
    end
  end

  // Commit acceptance, release and alternation. A half still marked full
  // rejects commits, including in the cycle it is being released.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      full       <= 2'b00;
      cnt        <= '0;
      cur_sel    <= BUF_PING;
      err_commit <= 1'b0;
    end else begin
      if (commit_valid && !commit_ok) err_commit <= 1'b1;
      if (commit_ok) begin
        full[commit_sel] <= 1'b1;
        cnt[commit_sel]  <= commit_cnt;
      end
      if (release_now) begin
        full[cur_sel] <= 1'b0;
        cur_sel       <= other_buf(cur_sel);
      end
    end
  end

  // In-flight read tags travel alongside the buffer latency.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      pipe_sel  <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue & issue_last;
      pipe_sel[0]  <= cur_sel;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_sel[i]  <= pipe_sel[i-1];
      end
    end
  end

  assign push_data = {pipe_last[RD_LATENCY-1], pipe_sel[RD_LATENCY-1], rd_data};

  dual_buffer_out_fifo #(
    .W (DATA_WIDTH + 2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_i),
    .in_valid  (push),
    .in_data   (push_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_data),
    .occ       (fifo_occ)
  );

  assign out_data    = head_data[DATA_WIDTH-1:0];
  assign out_buf_sel = head_data[DATA_WIDTH];
  assign out_last    = head_data[DATA_WIDTH+1];

endmodule

// File: tb/tb_dual_buffer_reader.sv
// Directed bench for dual_buffer_reader with a 1-cycle buffer model.
module tb_dual_buffer_reader;

  localparam int DW = 32;
  localparam int NP = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          commit_valid;
  logic          commit_sel;
  logic [CW-1:0] commit_cnt;
  logic          release_valid;
  logic          release_sel;
  logic          rd_buf_sel;
  logic [IW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_buf_sel;
  logic          err_commit;

  always #5 clk = ~clk;

  dual_buffer_reader #(
    .DATA_WIDTH             (DW),
    .NUM_PACKETS_PER_BUFFER (NP),
    .RD_LATENCY             (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .commit_valid  (commit_valid),
    .commit_sel    (commit_sel),
    .commit_cnt    (commit_cnt),
    .release_valid (release_valid),
    .release_sel   (release_sel),
    .rd_buf_sel    (rd_buf_sel),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_buf_sel   (out_buf_sel),
    .err_commit    (err_commit)
  );

  // Packet buffer model: synchronous read, one cycle of latency.
  logic [DW-1:0] mem [2][NP];
  always @(posedge clk) rd_data <= mem[rd_buf_sel][rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Stream / release monitor, sampled on the falling edge.
  logic [33:0] rx_q[$];
  int          rx_cyc[$];
  int          rel_q[$];
  int          rel_cyc[$];
  logic [33:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [33:0] stall_val;
  int          max_use = 0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {out_valid, out_buf_sel, out_last, out_data}, {1'b1, stall_val});
      if (out_valid && out_ready) begin
        rx_q.push_back({out_buf_sel, out_last, out_data});
        rx_cyc.push_back(cyc);
      end
      if (release_valid) begin
        rel_q.push_back(int'(release_sel));
        rel_cyc.push_back(cyc);
      end
      stall_prev <= out_valid && !out_ready;
      stall_val  <= {out_buf_sel, out_last, out_data};
      if (int'(dut.fifo_occ) + int'(dut.inflight) > max_use)
        max_use <= int'(dut.fifo_occ) + int'(dut.inflight);
    end
  end

  function automatic int rxc(input int i);
    return (i < rx_cyc.size()) ? rx_cyc[i] : -1000;
  endfunction
  function automatic int rels(input int i);
    return (i < rel_q.size()) ? rel_q[i] : -1;
  endfunction
  function automatic int relc(input int i);
    return (i < rel_cyc.size()) ? rel_cyc[i] : -1000;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    rx_q.delete(); rx_cyc.delete(); rel_q.delete(); rel_cyc.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; commit_valid = 1'b0; out_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    clear_q();
  endtask

  // Pulse a commit; it is sampled on the next edge, recorded in last_e0.
  int last_e0;
  task automatic cmt(input int sel, input int cnt);
    commit_valid = 1'b1; commit_sel = 1'(sel); commit_cnt = CW'(cnt);
    step(1);
    commit_valid = 1'b0;
    last_e0 = cyc;
  endtask

  task automatic fill(input int sel, input int tid);
    for (int i = 0; i < NP; i++)
      mem[sel][i] = 32'hA500_0000 | 32'(tid << 16) | 32'(sel << 8) | 32'(i);
  endtask

  task automatic add_exp(input int sel, input int cnt);
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({1'(sel), 1'(i == cnt - 1), mem[sel][i]});
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_npkt"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_pkt"}, (i < rx_q.size()) ? rx_q[i] : '1, exp_q[i]);
  endtask

  int c0;
  int pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_sel = 1'b0; commit_cnt = '0; out_ready = 1'b1;
    for (int s = 0; s < 2; s++) for (int i = 0; i < NP; i++) mem[s][i] = '0;
    step(2);
    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_misc", {release_valid, rd_buf_sel, rd_addr, out_last, out_buf_sel, err_commit}, 0);
    rst = 1'b0;
    step(4);
    clear_q();

    // Basic read-out: ping, 3 packets
    fill(0, 1);
    cmt(0, 3); c0 = last_e0;
    step(10);
    chk("t1_first_lat", rxc(0) - c0, 2);
    chk("t1_third_cyc", rxc(2) - c0, 4);
    chk("t1_rel_n", rel_q.size(), 1);
    chk("t1_rel_sel", rels(0), 0);
    chk("t1_rel_cyc", relc(0) - c0, 3);
    add_exp(0, 3);
    check_out("t1");

    // Back-to-back halves, 8 + 8
    do_reset();
    fill(0, 2); fill(1, 3);
    cmt(0, 8); c0 = last_e0;
    cmt(1, 8);
    step(30);
    chk("t2_first_lat", rxc(0) - c0, 2);
    chk("t2_ping_rate", rxc(7) - rxc(0), 7);
    chk("t2_gap_le1", (rxc(8) - rxc(7)) <= 2, 1);
    chk("t2_pong_rate", rxc(15) - rxc(8), 7);
    chk("t2_rel_n", rel_q.size(), 2);
    chk("t2_rel0", rels(0), 0);
    chk("t2_rel1", rels(1), 1);
    add_exp(0, 8); add_exp(1, 8);
    check_out("t2");

    // Backpressure: fixed pattern then random ready
    do_reset();
    fill(0, 4);
    max_use = 0;
    cmt(0, 4);
    for (int k = 0; k < 40; k++) begin
      out_ready = (k < 8) ? 1'(pat[k]) : 1'($urandom_range(0, 1));
      step(1);
    end
    out_ready = 1'b1;
    step(10);
    chk("t3_credit_le2", max_use <= 2, 1);
    chk("t3_rel_n", rel_q.size(), 1);
    add_exp(0, 4);
    check_out("t3");

    // Illegal: cnt = 0
    do_reset();
    chk("t4_err_clear", err_commit, 0);
    fill(0, 5);
    cmt(0, 0);
    step(6);
    chk("t4a_err", err_commit, 1);
    chk("t4a_npkt", rx_q.size(), 0);
    // Illegal: cnt = 9 > N
    do_reset();
    cmt(0, 9);
    step(6);
    chk("t4b_err", err_commit, 1);
    chk("t4b_npkt", rx_q.size(), 0);
    // Illegal: second commit to a full ping
    do_reset();
    cmt(0, 2);
    cmt(0, 3);
    step(8);
    chk("t4c_err", err_commit, 1);
    chk("t4c_rel_n", rel_q.size(), 1);
    add_exp(0, 2);
    check_out("t4c");
    clear_q();
    // Illegal: commit in the cycle ping is being released
    do_reset();
    cmt(0, 1);
    step(1);
    cmt(0, 1);
    step(8);
    chk("t4d_err", err_commit, 1);
    chk("t4d_rel_n", rel_q.size(), 1);
    add_exp(0, 1);
    check_out("t4d");
    clear_q();
    // Later legal pong traffic is unaffected, error stays set
    fill(1, 6);
    cmt(1, 2);
    step(8);
    chk("t4e_err_sticky", err_commit, 1);
    add_exp(1, 2);
    check_out("t4e");

    // Reset mid-operation
    do_reset();
    fill(0, 7);
    cmt(0, 5);
    step(2);
    rst = 1'b1;
    #1;
    chk("t5_rst_ctl", {out_valid, release_valid, out_last, out_buf_sel, rd_buf_sel, rd_addr, err_commit}, 0);
    chk("t5_rst_data", out_data, 0);
    step(2);
    rst = 1'b0;
    step(4);
    chk("t5_no_rel", rel_q.size(), 0);
    chk("t5_no_pkt", rx_q.size(), 0);
    clear_q();
    fill(1, 8);
    cmt(1, 2);
    step(10);
    chk("t5_pong_waits", rx_q.size(), 0);
    fill(0, 9);
    cmt(0, 1);
    step(12);
    chk("t5_rel_n", rel_q.size(), 2);
    chk("t5_rel0", rels(0), 0);
    chk("t5_rel1", rels(1), 1);
    add_exp(0, 1); add_exp(1, 2);
    check_out("t5");

    // Ordering: pong committed first still waits for ping
    do_reset();
    fill(1, 10);
    cmt(1, 3);
    step(8);
    chk("t6_pong_waits", rx_q.size(), 0);
    fill(0, 11);
    cmt(0, 2);
    step(14);
    chk("t6_rel0", rels(0), 0);
    chk("t6_rel1", rels(1), 1);
    add_exp(0, 2); add_exp(1, 3);
    check_out("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_buffer_reader.md
Name: dual_buffer_reader

Overview:
- Read-side controller for the ping-pong packet buffer.
- The writer commits a filled half (ping/pong) with a packet count. This block drives that half's read address and buffer select, then captures the 1-cycle-latency read data.
- Captured packets go out on a valid/ready stream with a per-buffer last flag, and the half is released back to the writer once every packet has been read.
- It sits between the packet buffer and the host transfer engine (DMA/stream sink).

Parameters:
- DATA_WIDTH, 16000, packet width in bits; must match the buffer's data width.
- NUM_PACKETS_PER_BUFFER, 8, depth of one half; power of two, ≥2.
- RD_LATENCY, 1, buffer read latency in cycles; only 1 is supported, and elaboration fails on any other value.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- commit_valid  in  1  one-cycle pulse: the writer has finished the half given by commit_sel.
- commit_sel  in  1  half being committed (0 = ping, 1 = pong).
- commit_cnt  in  $clog2(NUM_PACKETS_PER_BUFFER)+1  number of packets in the half, 1..NUM_PACKETS_PER_BUFFER.
- release_valid  out  1  one-cycle pulse: the half given by release_sel is free for writing.
- release_sel  out  1  half being released.
- rd_buf_sel  out  1  buffer read select.
- rd_addr  out  $clog2(NUM_PACKETS_PER_BUFFER)  buffer read address.
- rd_data  in  DATA_WIDTH  buffer read data, valid RD_LATENCY cycles after the address.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_WIDTH  packet.
- out_last  out  1  packet is the last one of its half.
- out_buf_sel  out  1  half the packet came from.
- err_commit  out  1  sticky flag: an illegal commit was seen; cleared only by rst.

Behaviour:
- Reset (async assert, sync deassert on the clk domain) clears the following:
  - full[1:0], cnt[1:0] and cur_sel (reset to 0).
  - The FSM returns to IDLE and the FIFO is emptied.
  - Outputs: release_valid=0, out_valid=0, out_last=0, out_buf_sel=0, out_data=0, rd_addr=0, rd_buf_sel=0, err_commit=0.
  - In-flight reads are discarded, and no release is issued for them.
- Commit handling:
  - A commit with commit_cnt in 1..N to a half whose full bit is clear sets full[sel] and latches cnt[sel].
  - A commit with cnt==0, with cnt>N, or to a half that is already full is ignored and sets err_commit.
  - This includes a commit arriving in the same cycle that half's release is pulsed: the release wins, and the commit counts as an error.
- Halves are served strictly in alternation, starting with ping. cur_sel toggles only after a half is released.
- FSM has three states:
  - IDLE: when full[cur_sel] is set, go to ISSUE with rd_idx=0.
  - ISSUE: rd_buf_sel=cur_sel, rd_addr=rd_idx. A read is issued in a cycle when (FIFO occupancy + reads in flight) < 2; then rd_idx increments. After issuing rd_idx==cnt-1, go to WAIT.
  - WAIT: the cycle the last packet's data is written into the FIFO:
    - pulse release_valid with release_sel=cur_sel
    - clear full[cur_sel], toggle cur_sel
    - return to IDLE.
- Reads in flight are tracked with a RD_LATENCY-deep valid/last/sel pipe. rd_data is captured into a 2-entry FIFO, together with last = (idx==cnt-1) and sel.
- Output stream follows the standard valid/ready handshake:
  - out_* come from the FIFO head and are held stable while out_valid && !out_ready.
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle are allowed when the FIFO is full.
- Latency: commit sampled at edge E0, first read issued in the cycle after E0, out_valid high after E2 (2 cycles).
- Throughput: 1 packet/cycle with out_ready held high.
- Back-to-back halves: if the other half is already full at release, IDLE lasts 1 cycle, so the gap between halves is ≤1 bubble.
- The FIFO never overflows because of the credit rule in ISSUE.
- Released halves can be rewritten immediately: all data for that half has already been captured.

Decomposition:
- Package dual_buffer_pkg holds:
  - localparams PKT_IDX_W = $clog2(N) and PKT_CNT_W = PKT_IDX_W+1
  - the enum state_e {IDLE, ISSUE, WAIT}
  - typedef buf_sel_t (logic), with constants BUF_PING=0 and BUF_PONG=1.
- Sub-module dual_buffer_out_fifo: a 2-entry DATA_WIDTH+2 valid/ready FIFO exposing occupancy, used for the output staging.

Test Plan:
- Basic read-out: commit ping, cnt=3, with rd_data modelled as a 1-cycle buffer model holding {A,B,C}, out_ready=1 → out_data A,B,C on consecutive cycles, first out_valid 2 cycles after the commit, out_last only on C, release_valid with sel=0 exactly once, in the cycle C enters the FIFO.
- Back-to-back halves: commit ping cnt=8, then pong cnt=8 one cycle later → 16 packets in order ping0..7 then pong0..7, ≤1 bubble between halves, releases for sel 0 then sel 1.
- Backpressure: cnt=4 with out_ready toggling 1,0,0,1,... and randomly → no loss or duplication, out_data stable while stalled, reads in flight + occupancy never exceeds 2.
- Illegal commits: cnt=0; cnt=9 with N=8; second commit to an already-full ping → each ignored, err_commit set and sticky, later legal traffic unaffected.
- Reset mid-operation: assert rst during ISSUE after 2 of 5 packets → all outputs 0 immediately, no release; after reset, commit pong cnt=2 → it waits, because ping is served first; commit ping cnt=1 → ping is served, then pong.
- Ordering across halves: commit pong first, then ping → no output until ping is committed; then ping is served, followed by pong.
